// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the SM83 memory bus controller and its address decoder.
// Other bus targets decode against the same memory-map constants.
package mem_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StWait   = 2'd2,
    StResp   = 2'd3
  } bus_state_e;

  localparam logic [15:0] DefaultBootTop     = 16'h00FF;
  localparam logic [15:0] DefaultBootRegAddr = 16'hFF50;

  // Memory map region bases
  localparam logic [15:0] MapCartRomBase = 16'h0000;
  localparam logic [15:0] MapVramBase    = 16'h8000;
  localparam logic [15:0] MapExtRamBase  = 16'hA000;
  localparam logic [15:0] MapWramBase    = 16'hC000;
  localparam logic [15:0] MapOamBase     = 16'hFE00;
  localparam logic [15:0] MapIoBase      = 16'hFF00;
  localparam logic [15:0] MapHramBase    = 16'hFF80;

  localparam int unsigned CntWidth = 4;

endpackage

// File: rtl/mem_addr_decode.sv
// Combinational decode of a bus address into boot-ROM window, external target
// or the boot-disable register.
module mem_addr_decode
  import mem_bus_ctrl_pkg::*;
#(
  parameter logic [15:0] BOOT_TOP      = DefaultBootTop,
  parameter logic [15:0] BOOT_REG_ADDR = DefaultBootRegAddr
) (
  input  logic [15:0] addr,
  input  logic        boot_en,
  output logic        rom,
  output logic        ext,
  output logic        boot_reg
);

  always_comb begin
    boot_reg = (addr == BOOT_REG_ADDR);
    rom      = boot_en && (addr <= BOOT_TOP) && !boot_reg;
    ext      = !rom && !boot_reg;
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Single-outstanding bus master between the SM83 core request port and the shared
// memory bus; owns the boot-ROM overlay. All outputs are registered.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int unsigned READ_LATENCY  = 1,
  parameter logic [15:0] BOOT_TOP      = DefaultBootTop,
  parameter logic [15:0] BOOT_REG_ADDR = DefaultBootRegAddr
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] bus_addr,
  output logic        bus_en,
  output logic        bus_oe,
  output logic        bus_we,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_din,
  output logic        rom_sel,
  output logic        ext_sel,
  output logic        boot_en
);

  localparam logic [CntWidth-1:0] CntInit = CntWidth'(READ_LATENCY);

  bus_state_e          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [7:0]          rsp_rdata_q, rsp_rdata_d;
  logic [15:0]         bus_addr_q, bus_addr_d;
  logic                bus_en_q, bus_en_d;
  logic                bus_oe_q, bus_oe_d;
  logic                bus_we_q, bus_we_d;
  logic [7:0]          bus_wdata_q, bus_wdata_d;
  logic                rom_sel_q, rom_sel_d;
  logic                ext_sel_q, ext_sel_d;
  logic                boot_en_q, boot_en_d;
  logic                dec_rom, dec_ext, dec_boot_reg;

  mem_addr_decode #(
    .BOOT_TOP      (BOOT_TOP),
    .BOOT_REG_ADDR (BOOT_REG_ADDR)
  ) u_decode (
    .addr     (req_addr),
    .boot_en  (boot_en_q),
    .rom      (dec_rom),
    .ext      (dec_ext),
    .boot_reg (dec_boot_reg)
  );

  // Next-state values are the outputs for the state being entered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    bus_addr_d  = bus_addr_q;
    bus_en_d    = 1'b0;
    bus_oe_d    = bus_oe_q;
    bus_we_d    = 1'b0;
    bus_wdata_d = bus_wdata_q;
    rom_sel_d   = rom_sel_q;
    ext_sel_d   = ext_sel_q;
    boot_en_d   = boot_en_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          we_d        = req_we;
          if (dec_boot_reg) begin
            // Boot register is internal: answer directly without touching the bus.
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            if (req_we) begin
              if (req_wdata != 8'h00) boot_en_d = 1'b0;
            end else begin
              rsp_rdata_d = {7'h7F, ~boot_en_q};
            end
          end else begin
            state_d    = StAccess;
            bus_en_d   = 1'b1;
            bus_addr_d = req_addr;
            bus_oe_d   = !req_we;
            bus_we_d   = req_we;
            if (req_we) bus_wdata_d = req_wdata;
            rom_sel_d  = dec_rom;
            ext_sel_d  = dec_ext;
          end
        end
      end
      StAccess: begin
        if (we_q) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          bus_oe_d    = 1'b0;
          rom_sel_d   = 1'b0;
          ext_sel_d   = 1'b0;
        end else begin
          state_d = StWait;
          cnt_d   = CntInit;
        end
      end
      StWait: begin
        if (cnt_q == CntWidth'(1)) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = bus_din;
          bus_oe_d    = 1'b0;
          rom_sel_d   = 1'b0;
          ext_sel_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      StResp: begin
        state_d     = StIdle;
        req_ready_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      bus_addr_q  <= 16'h0000;
      bus_en_q    <= 1'b0;
      bus_oe_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_wdata_q <= 8'h00;
      rom_sel_q   <= 1'b0;
      ext_sel_q   <= 1'b0;
      boot_en_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      bus_addr_q  <= bus_addr_d;
      bus_en_q    <= bus_en_d;
      bus_oe_q    <= bus_oe_d;
      bus_we_q    <= bus_we_d;
      bus_wdata_q <= bus_wdata_d;
      rom_sel_q   <= rom_sel_d;
      ext_sel_q   <= ext_sel_d;
      boot_en_q   <= boot_en_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bus_addr  = bus_addr_q;
  assign bus_en    = bus_en_q;
  assign bus_oe    = bus_oe_q;
  assign bus_we    = bus_we_q;
  assign bus_wdata = bus_wdata_q;
  assign rom_sel   = rom_sel_q;
  assign ext_sel   = ext_sel_q;
  assign boot_en   = boot_en_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: two instances (read latency 1 and 3) checked cycle by cycle
// against an access-level model of the bus protocol and boot overlay.
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]       req_valid, req_ready, req_we, rsp_valid;
  logic [1:0][15:0] req_addr, bus_addr;
  logic [1:0][7:0]  req_wdata, rsp_rdata, bus_wdata, bus_din;
  logic [1:0]       bus_en, bus_oe, bus_we, rom_sel, ext_sel, boot_en;

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         boot_m   [2];
  logic [7:0] last_rd  [2];
  logic [7:0] rd_data  [2];
  int         age      [2];

  function automatic int lat(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  mem_bus_ctrl #(.READ_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .bus_addr(bus_addr[0]),
    .bus_en(bus_en[0]), .bus_oe(bus_oe[0]), .bus_we(bus_we[0]), .bus_wdata(bus_wdata[0]),
    .bus_din(bus_din[0]), .rom_sel(rom_sel[0]), .ext_sel(ext_sel[0]), .boot_en(boot_en[0])
  );

  mem_bus_ctrl #(.READ_LATENCY(3)) dut_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .bus_addr(bus_addr[1]),
    .bus_en(bus_en[1]), .bus_oe(bus_oe[1]), .bus_we(bus_we[1]), .bus_wdata(bus_wdata[1]),
    .bus_din(bus_din[1]), .rom_sel(rom_sel[1]), .ext_sel(ext_sel[1]), .boot_en(boot_en[1])
  );

  // Synchronous-RAM target: data is valid only in the cycle READ_LATENCY clocks after
  // the enable cycle; every other cycle carries the complement as junk.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (bus_en[d] && bus_oe[d]) age[d] <= 1;
      else if (age[d] > 0 && age[d] < 32) age[d] <= age[d] + 1;
    end
  end
  assign bus_din[0] = (age[0] == lat(0)) ? rd_data[0] : ~rd_data[0];
  assign bus_din[1] = (age[1] == lat(1)) ? rd_data[1] : ~rd_data[1];

  task automatic check(int d, string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL d%0d %s: observed %0h expected %0h", d, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      boot_m[d]  = 1'b1;
      last_rd[d] = 8'h00;
    end
  endtask

  // Issue one request at a negedge and check every cycle up to and after its response.
  task automatic txn(int d, bit we, logic [15:0] addr, logic [7:0] wdata, logic [7:0] din,
                     bit hold);
    bit         is_reg, rom;
    int         n;
    logic [7:0] exp_rd;
    is_reg = (addr == 16'hFF50);
    rom    = boot_m[d] && (addr <= 16'h00FF) && !is_reg;
    n      = is_reg ? 1 : (we ? 2 : lat(d) + 2);
    exp_rd = is_reg ? {7'h7F, ~boot_m[d]} : din;
    check(d, "ready_before", req_ready[d], 1);
    check(d, "boot_en_before", boot_en[d], boot_m[d]);
    rd_data[d]   = din;
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    @(posedge clk);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check(d, "rsp_valid", rsp_valid[d], (k == n));
      check(d, "ready_busy", req_ready[d], 0);
      if (k < n) begin
        check(d, "bus_en", bus_en[d], (k == 1));
        check(d, "bus_addr", bus_addr[d], addr);
        check(d, "bus_oe", bus_oe[d], !we);
        check(d, "bus_we", bus_we[d], (we && k == 1));
        check(d, "rom_sel", rom_sel[d], rom);
        check(d, "ext_sel", ext_sel[d], !rom);
        if (we) check(d, "bus_wdata", bus_wdata[d], wdata);
      end else begin
        check(d, "resp_strobes", {bus_en[d], bus_oe[d], bus_we[d], rom_sel[d], ext_sel[d]}, 0);
        check(d, "rsp_rdata", rsp_rdata[d], we ? last_rd[d] : exp_rd);
      end
      // A held or changing request while busy must not start a second access.
      if (hold && k < n) begin
        req_addr[d] = 16'($urandom);
        req_we[d]   = 1'($urandom);
      end else begin
        req_valid[d] = 1'b0;
      end
    end
    if (is_reg && we && wdata != 8'h00) boot_m[d] = 1'b0;
    if (!we) last_rd[d] = exp_rd;
    @(negedge clk);
    check(d, "ready_after", req_ready[d], 1);
    check(d, "rsp_after", {rsp_valid[d], bus_en[d]}, 0);
    check(d, "rdata_hold", rsp_rdata[d], last_rd[d]);
    check(d, "boot_en_after", boot_en[d], boot_m[d]);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         d, r;
    bit         we;
    logic [15:0] a;
    logic [7:0]  w;
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 2; i++) begin
      rd_data[i] = 8'h00;
      age[i]     = 0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check(i, "rst_ready_boot", {req_ready[i], boot_en[i]}, 2'b11);
      check(i, "rst_zero", {rsp_valid[i], rsp_rdata[i], bus_en[i], bus_oe[i], bus_we[i],
                            bus_addr[i], bus_wdata[i], rom_sel[i], ext_sel[i]}, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Latency 1: ROM read, boot disable, then external read and register readback.
    txn(0, 0, 16'h0010, 8'h00, 8'h31, 0);
    txn(0, 1, 16'hFF50, 8'h01, 8'h00, 0);
    txn(0, 0, 16'h0010, 8'h00, 8'h6C, 0);
    txn(0, 0, 16'hFF50, 8'h00, 8'h00, 0);

    // Latency 3: zero write keeps boot on, window boundaries, held request, write.
    txn(1, 1, 16'hFF50, 8'h00, 8'h00, 0);
    txn(1, 0, 16'hFF50, 8'h00, 8'h00, 0);
    txn(1, 0, 16'h00FF, 8'h00, 8'h4B, 0);
    txn(1, 0, 16'h0100, 8'h00, 8'h92, 0);
    txn(1, 1, 16'h0020, 8'h77, 8'h00, 0);
    txn(1, 0, 16'hC000, 8'h00, 8'hA5, 1);
    txn(1, 1, 16'hC123, 8'h5A, 8'h00, 1);

    // Reset during WAIT after boot was disabled.
    txn(1, 1, 16'hFF50, 8'h01, 8'h00, 0);
    rd_data[1] = 8'h3C;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 16'hC000;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check(1, "in_wait_oe", bus_oe[1], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check(1, "rst_mid_strobes", {bus_en[1], bus_oe[1], bus_we[1], rom_sel[1], ext_sel[1]}, 0);
    check(1, "rst_mid_rsp", rsp_valid[1], 0);
    check(1, "rst_mid_ready_boot", {req_ready[1], boot_en[1]}, 2'b11);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check(1, "no_rsp_after_abort", {rsp_valid[1], bus_en[1]}, 0);
    end

    // Randomized traffic across ROM window, boundary, boot register and the rest.
    for (int i = 0; i < 80; i++) begin
      if (i % 25 == 24) pulse_reset();
      d  = int'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 5));
      we = 1'($urandom);
      w  = 8'($urandom);
      case (r)
        0, 1: a = 16'($urandom_range(0, 255));
        2: begin
          a = 16'hFF50;
          if ($urandom_range(0, 2) == 0) w = 8'h00;
        end
        3: a = ($urandom_range(0, 1) == 0) ? 16'h00FF : 16'h0100;
        default: a = 16'($urandom);
      endcase
      txn(d, we, a, w, 8'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
